// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Entries carry the returned instruction word together with the PC it was fetched from.
package fetch_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush, used for both the instruction queue and the PC tag queue.
// Head reads straight from the storage registers; it is forced to zero while empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = ENTRY_W,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [CntW-1:0]  count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CntW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full queue is only legal when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign count   = count_q;
    assign head    = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC generation, credit-limited memory requests, in-order
// response tagging and a small output queue toward decode, with redirect flushing.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     FQ_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               instr_valid_out,
    input  logic               instr_ready_in,
    output logic [INSTR_W-1:0] instruction_out,
    output logic [XLEN-1:0]    pc_out
);

    localparam int unsigned CntW = $clog2(FQ_DEPTH) + 1;
    localparam int unsigned SumW = CntW + 2;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CntW-1:0] inflight_q, inflight_d;
    logic [CntW-1:0] drop_q, drop_d;

    logic            fq_full, fq_empty;
    logic [CntW-1:0] fq_count;
    fetch_entry_t    fq_push_entry, fq_head;

    logic            tq_full, tq_empty;
    logic [CntW-1:0] tq_count;
    logic [XLEN-1:0] tq_head;

    logic [SumW-1:0] credit_used;
    logic            req_fire;
    logic            rsp_drop;
    logic            rsp_take;
    logic            pop_fire;

    // Every slot that could still land in the output queue holds a credit: buffered
    // entries, live requests, and wrong-path requests whose responses must be dropped.
    assign credit_used    = SumW'(inflight_q) + SumW'(fq_count) + SumW'(drop_q);
    assign imem_req_valid = rst_n && !redirect_valid && (credit_used < SumW'(FQ_DEPTH));
    assign imem_req_addr  = pc_q;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_drop = imem_rsp_valid && (drop_q != '0);
    assign rsp_take = imem_rsp_valid && (drop_q == '0);
    assign pop_fire = instr_valid_out && instr_ready_in;

    assign fq_push_entry = '{instr: imem_rsp_data, pc: tq_head};

    always_comb begin
        pc_d       = pc_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        if (rsp_drop) begin
            drop_d = drop_q - CntW'(1);
        end
        if (redirect_valid) begin
            pc_d       = redirect_pc;
            inflight_d = '0;
            // A live response arriving now is flushed with the queue, so it needs no drop.
            drop_d     = drop_d + inflight_q - CntW'(rsp_take);
        end else begin
            if (req_fire) begin
                pc_d = next_pc(pc_q);
            end
            case ({req_fire, rsp_take})
                2'b10:   inflight_d = inflight_q + CntW'(1);
                2'b01:   inflight_d = inflight_q - CntW'(1);
                default: inflight_d = inflight_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FQ_DEPTH),
        .WIDTH (XLEN)
    ) u_tag_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (req_fire),
        .push_data (pc_q),
        .pop       (rsp_take),
        .flush     (redirect_valid),
        .full      (tq_full),
        .empty     (tq_empty),
        .count     (tq_count),
        .head      (tq_head)
    );

    fetch_fifo #(
        .DEPTH (FQ_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_out_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rsp_take),
        .push_data (fq_push_entry),
        .pop       (instr_ready_in),
        .flush     (redirect_valid),
        .full      (fq_full),
        .empty     (fq_empty),
        .count     (fq_count),
        .head      (fq_head)
    );

    assign instr_valid_out = !fq_empty;
    assign instruction_out = fq_head.instr;
    assign pc_out          = fq_head.pc;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_take |-> !fq_full);
    a_tag_present: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_take |-> !tq_empty);
    a_tag_room: assert property (@(posedge clk) disable iff (!rst_n)
        req_fire |-> !tq_full);
    a_tag_tracks: assert property (@(posedge clk) disable iff (!rst_n)
        tq_count == inflight_q);
    a_pop_legal: assert property (@(posedge clk) disable iff (!rst_n)
        pop_fire |-> !fq_empty);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run, all
// checked against a program-order model (expected next fetch PC and next delivered PC).
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int unsigned FQ = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        instr_valid_out;
    logic        instr_ready_in = 1'b0;
    logic [31:0] instruction_out;
    logic [31:0] pc_out;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (RST_PC),
        .FQ_DEPTH (FQ)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .instr_valid_out (instr_valid_out),
        .instr_ready_in  (instr_ready_in),
        .instruction_out (instruction_out),
        .pc_out          (pc_out)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lat_min = 1;
    int lat_max = 1;
    int npops = 0;

    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] issued_addr[$];
    int          acc_cyc[$];
    logic [31:0] popped_pc[$];
    logic [31:0] popped_ins[$];
    int          pop_cyc[$];
    logic [31:0] exp_pc;
    logic [31:0] req_exp;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h09A0_0293;
            32'h4:   return 32'h000B_EF37;
            32'h8:   return 32'hBAD0_0193;
            32'hC:   return 32'h0000_0000;
            32'h10:  return NOP_INSTR;
            default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
        endcase
    endfunction

    // One clock: observe the settled cycle at negedge, then act as the memory after the edge.
    task automatic tick();
        @(negedge clk);
        if (rst_n) begin
            if (imem_req_valid && imem_req_ready) begin
                checks++;
                if (imem_req_addr !== req_exp) begin
                    errors++;
                    $display("FAIL req_addr: got %h want %h", imem_req_addr, req_exp);
                end
                mq_addr.push_back(imem_req_addr);
                mq_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
                issued_addr.push_back(imem_req_addr);
                acc_cyc.push_back(cyc);
                req_exp = imem_req_addr + 32'd4;
                checks++;
                if (mq_addr.size() + int'(imem_rsp_valid) > FQ) begin
                    errors++;
                    $display("FAIL credit: outstanding %0d want <= %0d",
                             mq_addr.size() + int'(imem_rsp_valid), FQ);
                end
            end
            if (instr_valid_out && instr_ready_in) begin
                checks++;
                if (pc_out !== exp_pc || instruction_out !== imem_word(exp_pc)) begin
                    errors++;
                    $display("FAIL deliver: got pc=%h ins=%h want pc=%h ins=%h",
                             pc_out, instruction_out, exp_pc, imem_word(exp_pc));
                end
                popped_pc.push_back(pc_out);
                popped_ins.push_back(instruction_out);
                pop_cyc.push_back(cyc);
                npops++;
                exp_pc = exp_pc + 32'd4;
            end
            if (redirect_valid) begin
                checks++;
                if (imem_req_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL redirect_noreq: got %b want 0", imem_req_valid);
                end
                exp_pc  = redirect_pc;
                req_exp = redirect_pc;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = imem_word(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    task automatic apply_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        instr_ready_in = 1'b0;
        mq_addr.delete();
        mq_due.delete();
        issued_addr.delete();
        acc_cyc.delete();
        popped_pc.delete();
        popped_ins.delete();
        pop_cyc.delete();
        exp_pc  = RST_PC;
        req_exp = RST_PC;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (imem_req_valid !== 1'b0 || instr_valid_out !== 1'b0 ||
                instruction_out !== 32'h0 || pc_out !== 32'h0) begin
                errors++;
                $display("FAIL reset_outputs: got rv=%b iv=%b ins=%h pc=%h want 0 0 0 0",
                         imem_req_valid, instr_valid_out, instruction_out, pc_out);
            end
        end
        release_reset();
        #1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC || instr_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_req: got rv=%b addr=%h iv=%b want 1 %h 0",
                     imem_req_valid, imem_req_addr, instr_valid_out, RST_PC);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (instr_valid_out !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_instr: got %b want 0", instr_valid_out);
            end
        end
    endtask

    task automatic test_streaming();
        logic [31:0] want_ins [3];
        want_ins[0] = 32'h09A0_0293;
        want_ins[1] = 32'h000B_EF37;
        want_ins[2] = 32'hBAD0_0193;
        apply_reset();
        release_reset();
        lat_min = 1;
        lat_max = 1;
        imem_req_ready = 1'b1;
        instr_ready_in = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        checks++;
        if (popped_pc.size() < 6) begin
            errors++;
            $display("FAIL stream_count: got %0d want >= 6", popped_pc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (popped_pc[i] !== 32'(4 * i) || popped_ins[i] !== want_ins[i]) begin
                    errors++;
                    $display("FAIL stream_order[%0d]: got pc=%h ins=%h want pc=%h ins=%h",
                             i, popped_pc[i], popped_ins[i], 32'(4 * i), want_ins[i]);
                end
            end
            checks++;
            if (popped_ins[3] !== 32'h0) begin
                errors++;
                $display("FAIL stream_zero_word: got %h want 0", popped_ins[3]);
            end
            checks++;
            if (pop_cyc[0] - acc_cyc[0] != 2) begin
                errors++;
                $display("FAIL stream_latency: got %0d want 2", pop_cyc[0] - acc_cyc[0]);
            end
            for (int i = 1; i < 6; i++) begin
                checks++;
                if (pop_cyc[i] - pop_cyc[i-1] != 1) begin
                    errors++;
                    $display("FAIL stream_bubble[%0d]: got gap %0d want 1",
                             i, pop_cyc[i] - pop_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        release_reset();
        lat_min = 1;
        lat_max = 1;
        imem_req_ready = 1'b1;
        instr_ready_in = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        #1;
        checks++;
        if (issued_addr.size() != 4 || imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_credit: got issued=%0d rv=%b want 4 0",
                     issued_addr.size(), imem_req_valid);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (instr_valid_out !== 1'b1 || pc_out !== 32'h0 || instruction_out !== 32'h09A0_0293) begin
                errors++;
                $display("FAIL bp_hold: got iv=%b pc=%h ins=%h want 1 0 09a00293",
                         instr_valid_out, pc_out, instruction_out);
            end
        end
        instr_ready_in = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (popped_pc.size() < 4 || issued_addr.size() < 5) begin
            errors++;
            $display("FAIL bp_drain: got pops=%0d issued=%0d want >=4 >=5",
                     popped_pc.size(), issued_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (popped_pc[i] !== 32'(4 * i)) begin
                    errors++;
                    $display("FAIL bp_order[%0d]: got %h want %h", i, popped_pc[i], 32'(4 * i));
                end
            end
            checks++;
            if (issued_addr[4] !== 32'h10) begin
                errors++;
                $display("FAIL bp_resume: got %h want 00000010", issued_addr[4]);
            end
        end
    endtask

    task automatic test_redirect();
        apply_reset();
        release_reset();
        lat_min = 3;
        lat_max = 3;
        imem_req_ready = 1'b1;
        instr_ready_in = 1'b1;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100 || instr_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL redir_target: got rv=%b addr=%h iv=%b want 1 00000100 0",
                     imem_req_valid, imem_req_addr, instr_valid_out);
        end
        for (int i = 0; i < 12; i++) tick();
        checks++;
        if (popped_pc.size() == 0 || popped_pc[0] !== 32'h100) begin
            errors++;
            $display("FAIL redir_first_pc: got %h want 00000100",
                     popped_pc.size() == 0 ? 32'hxxxx_xxxx : popped_pc[0]);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        release_reset();
        lat_min = 1;
        lat_max = 1;
        imem_req_ready = 1'b1;
        instr_ready_in = 1'b1;
        tick();
        tick();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin
                errors++;
                $display("FAIL stall_hold: got rv=%b addr=%h want 1 00000008",
                         imem_req_valid, imem_req_addr);
            end
        end
        imem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (issued_addr.size() != 6 || issued_addr[2] !== 32'h8 || issued_addr[3] !== 32'hC) begin
            errors++;
            $display("FAIL stall_seq: got n=%0d a2=%h a3=%h want 6 00000008 0000000c",
                     issued_addr.size(), issued_addr[2], issued_addr[3]);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        release_reset();
        lat_min = 1;
        lat_max = 1;
        imem_req_ready = 1'b1;
        instr_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (instr_valid_out !== 1'b1 || popped_pc.size() != 0) begin
            errors++;
            $display("FAIL areset_setup: got iv=%b want 1", instr_valid_out);
        end
        #2;
        apply_reset();
        #1;
        checks++;
        if (instr_valid_out !== 1'b0 || pc_out !== 32'h0 || imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate: got iv=%b pc=%h rv=%b want 0 0 0",
                     instr_valid_out, pc_out, imem_req_valid);
        end
        @(posedge clk);
        release_reset();
        imem_req_ready = 1'b1;
        instr_ready_in = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (issued_addr.size() == 0 || issued_addr[0] !== RST_PC ||
            popped_pc.size() == 0 || popped_pc[0] !== RST_PC) begin
            errors++;
            $display("FAIL areset_restart: got issued=%0d popped=%0d want restart at %h",
                     issued_addr.size(), popped_pc.size(), RST_PC);
        end
    endtask

    task automatic test_random();
        int start_pops;
        apply_reset();
        release_reset();
        lat_min = 1;
        lat_max = 4;
        start_pops = npops;
        for (int i = 0; i < 3000; i++) begin
            imem_req_ready = ($urandom_range(3, 0) != 0);
            instr_ready_in = ($urandom_range(9, 0) < 7);
            redirect_valid = ($urandom_range(15, 0) == 0);
            if ($urandom_range(3, 0) == 0) redirect_pc = 32'hFFFF_FFF8;
            else                           redirect_pc = $urandom() & 32'hFFFF_FFFC;
            tick();
        end
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        instr_ready_in = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (npops - start_pops < 300) begin
            errors++;
            $display("FAIL random_progress: got %0d pops want >= 300", npops - start_pops);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect();
        test_stall();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
